// File: rtl/lc3_data_memory.sv
// Word-addressed data memory with a fixed access latency and a one-cycle completion strobe.
// A request is sampled in IDLE, counted down in BUSY, performed on the BUSY->DONE edge.
module lc3_data_memory #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rd,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        complete_data,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(LATENCY - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic            r_rd;
  logic [AW-1:0]   r_addr;
  logic [15:0]     r_din;
  logic [3:0]      r_cnt;
  logic [15:0]     r_mem [0:(1<<AW)-1];

  logic [AW-1:0]   w_addr;
  logic            w_rd_known;
  logic            w_bad_req;
  logic            w_sample;
  logic            w_do_access;

  assign w_addr = addr[AW-1:0];

  // x/z detection: a^a is all-zero for known bits, so this folds to a constant in synthesis.
  assign w_rd_known  = ((rd ^ rd) === 1'b0);
  assign w_bad_req   = ((w_addr ^ w_addr) !== '0) || (!rd && ((din ^ din) !== '0));
  assign w_sample    = (r_state == S_IDLE) && w_rd_known;
  assign w_do_access = (r_state == S_BUSY) && (r_cnt == 4'd0);

  generate
    if (AW < 16) begin : g_unused_addr
      logic w_unused_addr;
      assign w_unused_addr = ^addr[15:AW];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_rd_known) w_state_next = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    complete_data = (r_state == S_DONE);
  end

  // Latched request copies: the bus is ignored once an access is in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_din   <= 16'h0000;
      r_cnt   <= 4'd0;
      mem_err <= 1'b0;
    end else if (w_sample) begin
      r_rd   <= rd;
      r_addr <= w_addr;
      r_din  <= din;
      r_cnt  <= LP_CNT_LOAD;
      if (w_bad_req) begin
        mem_err <= 1'b1;
      end
    end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout <= 16'h0000;
    end else if (w_do_access && r_rd) begin
      dout <= r_mem[r_addr];
    end
  end

  // Array is never cleared; reset forces IDLE so an aborted write cannot commit.
  always_ff @(posedge clock) begin
    if (w_do_access && !r_rd) begin
      r_mem[r_addr] <= r_din;
    end
  end

endmodule

// File: tb/tb_lc3_data_memory.sv
// Bench for lc3_data_memory: a timestamp-based transaction model checked every cycle,
// plus directed accesses with hand-computed results.
module tb_lc3_data_memory;

  localparam int LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rd;
  logic [15:0] addr;
  logic [15:0] din;
  logic [15:0] dout;
  logic        complete_data;
  logic        mem_err;

  always #5 clock = ~clock;

  lc3_data_memory #(.AW(8), .LATENCY(LAT)) dut (
    .clock         (clock),
    .reset         (reset),
    .rd            (rd),
    .addr          (addr),
    .din           (din),
    .dout          (dout),
    .complete_data (complete_data),
    .mem_err       (mem_err)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit four_state  = 1'b0;
  bit checking    = 1'b0;

  // Model: a request sampled at edge e completes at e+LAT; the next sample is allowed at e+LAT+2.
  int          edge_cnt  = 0;
  int          next_free = 0;
  int          done_edge = 0;
  bit          pend      = 1'b0;
  logic        p_rd;
  logic [7:0]  p_addr;
  logic [15:0] p_din;
  logic [15:0] m_mem [256];
  bit          m_vld [256];
  logic [15:0] exp_dout = 16'h0000;
  bit          dout_dc  = 1'b0;
  logic        exp_cmp  = 1'b0;
  logic        exp_err  = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend      = 1'b0;
      exp_cmp   = 1'b0;
      exp_dout  = 16'h0000;
      dout_dc   = 1'b0;
      exp_err   = 1'b0;
      next_free = edge_cnt + 1;
    end else begin
      edge_cnt++;
      exp_cmp = 1'b0;
      if (pend && edge_cnt == done_edge) begin
        pend    = 1'b0;
        exp_cmp = 1'b1;
        if (p_rd) begin
          if ($isunknown(p_addr) || !m_vld[p_addr]) begin
            dout_dc = 1'b1;
          end else begin
            exp_dout = m_mem[p_addr];
            dout_dc  = 1'b0;
          end
        end else if (!$isunknown(p_addr)) begin
          m_mem[p_addr] = p_din;
          m_vld[p_addr] = 1'b1;
        end
      end
      if (edge_cnt >= next_free && !$isunknown(rd)) begin
        pend      = 1'b1;
        p_rd      = rd;
        p_addr    = addr[7:0];
        p_din     = din;
        done_edge = edge_cnt + LAT;
        next_free = edge_cnt + LAT + 2;
        if ($isunknown(addr[7:0]) || (rd == 1'b0 && $isunknown(din))) begin
          exp_err = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (checking && !reset) begin
      chk("model_complete", {15'd0, complete_data}, {15'd0, exp_cmp});
      chk("model_mem_err", {15'd0, mem_err}, {15'd0, exp_err});
      if (!dout_dc) chk("model_dout", dout, exp_dout);
    end
  end

  task automatic wait_free();
    int n = 0;
    while ((edge_cnt + 1 < next_free) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_free: memory still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic do_access(input logic r, input logic [15:0] a, input logic [15:0] d,
                           input bit chg, output logic [15:0] res, output int lat);
    wait_free();
    rd   = r;
    addr = a;
    din  = d;
    @(posedge clock);
    #1;
    if (chg) addr = a + 16'd1;
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (complete_data !== 1'b1 && lat < 20);
    if (complete_data !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL strobe_timeout: complete_data=%b after %0d cycles, required 1", complete_data, lat);
    end
    res = dout;
    $display("%s addr=%h din=%h -> dout=%h latency=%0d", r ? "RD" : "WR", a, d, res, lat);
  endtask

  logic        xprobe;
  logic [15:0] res;
  int          lat;

  initial begin
    xprobe     = 1'bx;
    four_state = $isunknown(xprobe);
    rd   = 1'bx;
    addr = 'x;
    din  = 'x;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_dout", dout, 16'h0000);
    chk("reset_complete", {15'd0, complete_data}, 16'd0);
    chk("reset_mem_err", {15'd0, mem_err}, 16'd0);
    reset    = 1'b0;
    checking = 1'b1;

    // Idle bus for 10 cycles
    repeat (10) begin
      @(negedge clock);
      if (four_state) chk("idle_complete", {15'd0, complete_data}, 16'd0);
    end
    if (four_state) begin
      chk("idle_dout", dout, 16'h0000);
      chk("idle_mem_err", {15'd0, mem_err}, 16'd0);
    end

    // Write then read back
    do_access(1'b0, 16'h0030, 16'hBEEF, 1'b0, res, lat);
    chk("wr_latency", 16'(lat), 16'd2);
    @(posedge clock);
    #1;
    chk("strobe_fall", {15'd0, complete_data}, 16'd0);
    do_access(1'b1, 16'h0030, 16'h0000, 1'b0, res, lat);
    chk("rd_30", res, 16'hBEEF);
    chk("rd_latency", 16'(lat), 16'd2);
    do_access(1'b0, 16'h0031, 16'h1111, 1'b0, res, lat);
    chk("dout_hold_on_write", res, 16'hBEEF);

    // Indirect read through dout
    do_access(1'b0, 16'h0010, 16'h0040, 1'b0, res, lat);
    do_access(1'b0, 16'h0040, 16'h1234, 1'b0, res, lat);
    do_access(1'b1, 16'h0010, 16'h0000, 1'b0, res, lat);
    chk("indirect_ptr", res, 16'h0040);
    do_access(1'b1, res, 16'h0000, 1'b0, res, lat);
    chk("indirect_data", res, 16'h1234);

    // Address changed one cycle after sampling
    do_access(1'b1, 16'h0030, 16'h0000, 1'b1, res, lat);
    chk("midaccess_addr", res, 16'hBEEF);
    do_access(1'b1, 16'h0031, 16'h0000, 1'b0, res, lat);
    chk("rd_31", res, 16'h1111);

    // Reset during an in-flight write
    do_access(1'b0, 16'h0044, 16'hAAAA, 1'b0, res, lat);
    wait_free();
    rd   = 1'b0;
    addr = 16'h0044;
    din  = 16'h5555;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_complete", {15'd0, complete_data}, 16'd0);
    chk("abort_dout", dout, 16'h0000);
    @(negedge clock);
    rd    = 1'b1;
    addr  = 16'h0044;
    reset = 1'b0;
    do_access(1'b1, 16'h0044, 16'h0000, 1'b0, res, lat);
    chk("abort_no_commit", res, 16'hAAAA);

    // Address wrap and sticky error
    do_access(1'b0, 16'h0107, 16'h7777, 1'b0, res, lat);
    do_access(1'b1, 16'h0007, 16'h0000, 1'b0, res, lat);
    chk("wrap_rd", res, 16'h7777);
    do_access(1'b1, 16'hxxxx, 16'h0000, 1'b0, res, lat);
    if (four_state) chk("err_set", {15'd0, mem_err}, 16'd1);
    rd   = 1'bx;
    addr = 'x;
    din  = 'x;
    repeat (5) @(negedge clock);
    if (four_state) chk("err_sticky", {15'd0, mem_err}, 16'd1);
    reset = 1'b1;
    #1;
    chk("err_cleared", {15'd0, mem_err}, 16'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
